// File: rtl/intt_job_ctrl.sv
// rtl/intt_job_ctrl.sv - sequences one transform job: feeds coefficient pairs into intt, collects results, flags errors
module intt_job_ctrl #(
  parameter int N_COEF  = 256,
  parameter int ADDR_W  = $clog2(N_COEF/2),
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              start_rdy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pipe_in_en,
  input  logic              pipe_out_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  localparam int BEATS = N_COEF / 2;
  localparam int TW    = $clog2(TIMEOUT + 1) + 1;
  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BEATS - 1);
  localparam logic [TW-1:0]     TO_VAL    = TW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_COLLECT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] wr_cnt;
  logic [RD_LAT-1:0] in_dly;
  logic [TW-1:0]     timer;
  logic              just_done;

  assign rd_addr    = rd_cnt;
  assign wr_addr    = wr_cnt;
  assign pipe_in_en = in_dly[RD_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      in_dly    <= '0;
      timer     <= '0;
      just_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_cnt    <= (state == S_FEED) ? rd_cnt + ADDR_W'(1) : '0;
      // any break in the out_en burst aborts the job, so the write counter restarts on every low cycle
      wr_cnt    <= wr_en ? wr_cnt + ADDR_W'(1) : '0;
      in_dly    <= (in_dly << 1) | RD_LAT'(rd_en);
      just_done <= done;
      // timer holds 1 in the cycle after each pipe_in_en beat and counts up from there, saturating at all-ones
      if (state == S_IDLE)
        timer <= '0;
      else if (pipe_in_en)
        timer <= TW'(1);
      else if (timer != '0 && timer != '1)
        timer <= timer + TW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    start_rdy = 1'b0;
    busy      = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    done      = 1'b0;
    err       = 2'b00;
    case (state)
      S_IDLE: begin
        start_rdy = 1'b1;
        // a new job waits until the previous out_en burst has fallen
        if (just_done && pipe_out_en)
          err = 2'b10;
        else if (start && !pipe_out_en)
          state_nxt = S_FEED;
      end
      S_FEED: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (rd_cnt == LAST_BEAT)
          state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (pipe_out_en) begin
          wr_en     = 1'b1;
          state_nxt = S_COLLECT;
        end else if (timer >= TO_VAL) begin
          err       = 2'b01;
          state_nxt = S_IDLE;
        end
      end
      S_COLLECT: begin
        busy = 1'b1;
        if (pipe_out_en) begin
          wr_en = 1'b1;
          if (wr_cnt == LAST_BEAT) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
        end else begin
          err       = 2'b10;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
